pipeline_trace_buffer: RTL and testbench

Synthesizable per-cycle trace recorder for the core pipeline. It captures up to CHANNELS valid-qualified probe words each cycle, for example IF→ID, ID→EX and EX→RF valids, writeback data and stall flags. Samples go into a circular buffer with a programmable pre/post-trigger split. After capture the buffer drains in order through a valid/ready stream. It replaces printf-style per-cycle dumps with an on-chip, depth- and channel-parametrised recorder usable in simulation and on FPGA.

---
 rtl/pipeline_trace_buffer_pkg.sv | 17 +
 rtl/pipeline_trace_buffer_trace_ram.sv | 30 +++
 rtl/pipeline_trace_buffer.sv | 183 ++++++++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_trace_buffer_pkg.sv
// Shared types for the pipeline trace recorder: FSM state encoding and entry sizing.
package pipeline_trace_buffer_pkg;

  typedef enum logic [2:0] {
    TRC_IDLE    = 3'd0,
    TRC_CAPTURE = 3'd1,
    TRC_POST    = 3'd2,
    TRC_DRAIN   = 3'd3,
    TRC_READ    = 3'd4
  } trc_state_e;

  // One stored entry is {stamp, ch_v, ch_data}.
  function automatic int trc_entry_width(input int cyc_w, input int channels, input int ch_w);
    return cyc_w + channels + channels * ch_w;
  endfunction

endpackage

// File: rtl/pipeline_trace_buffer_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port with read enable.
module pipeline_trace_buffer_trace_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Per-cycle pipeline probe recorder: circular capture with pre/post-trigger split,
// then an in-order valid/ready dump of the retained entries.
module pipeline_trace_buffer
  import pipeline_trace_buffer_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CH_WIDTH  = 32,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 32,
  parameter int CYC_WIDTH = 16,
  parameter int FILTER    = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         arm_i,
  input  logic [CHANNELS-1:0]                          ch_v_i,
  input  logic [CHANNELS*CH_WIDTH-1:0]                 ch_data_i,
  input  logic [CHANNELS-1:0]                          trig_mask_i,
  input  logic                                         trig_i,
  input  logic                                         rd_ready_i,
  output logic                                         rd_valid_o,
  output logic [CYC_WIDTH+CHANNELS+CHANNELS*CH_WIDTH-1:0] rd_data_o,
  output logic                                         rd_last_o,
  output logic                                         busy_o,
  output logic                                         triggered_o,
  output logic                                         overflow_o
);

  localparam int EW = trc_entry_width(CYC_WIDTH, CHANNELS, CH_WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0]        PTR_ONE = AW'(1);
  localparam logic [CW-1:0]        CNT_ONE = CW'(1);
  localparam logic [CW-1:0]        DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]        POST_C  = CW'(POST_TRIG);
  localparam logic [CYC_WIDTH-1:0] CYC_ONE = CYC_WIDTH'(1);

  trc_state_e           state_q, state_d;
  logic [CYC_WIDTH-1:0] cyc_q, cyc_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        remain_q, remain_d;
  logic [CW-1:0]        post_cnt_q, post_cnt_d;
  logic                 triggered_q, triggered_d;
  logic                 overflow_q, overflow_d;

  logic          we;
  logic          re;
  logic [AW-1:0] raddr;
  logic [EW-1:0] wdata;
  logic [EW-1:0] ram_rdata;
  logic          probe_qual;
  logic          trig_hit;

  assign wdata      = {cyc_q, ch_v_i, ch_data_i};
  assign probe_qual = (FILTER != 0) ? (|ch_v_i) : 1'b1;
  assign trig_hit   = trig_i | (|(ch_v_i & trig_mask_i));

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q + CYC_ONE;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    remain_d    = remain_q;
    post_cnt_d  = post_cnt_q;
    triggered_d = triggered_q;
    overflow_d  = overflow_q;
    we          = 1'b0;
    re          = 1'b0;
    raddr       = rd_ptr_q;

    case (state_q)
      TRC_IDLE: begin
        if (arm_i) begin
          state_d     = TRC_CAPTURE;
          wr_ptr_d    = '0;
          count_d     = '0;
          triggered_d = 1'b0;
          overflow_d  = 1'b0;
        end
      end
      TRC_CAPTURE: begin
        // The trigger cycle is stored even when the filter would drop it.
        we = probe_qual | trig_hit;
        if (trig_hit) begin
          triggered_d = 1'b1;
          post_cnt_d  = POST_C;
          state_d     = (POST_TRIG == 0) ? TRC_DRAIN : TRC_POST;
        end
      end
      TRC_POST: begin
        we = probe_qual;
        if (probe_qual) begin
          post_cnt_d = post_cnt_q - CNT_ONE;
          if (post_cnt_q == CNT_ONE) begin
            state_d = TRC_DRAIN;
          end
        end
      end
      TRC_DRAIN: begin
        re       = 1'b1;
        raddr    = (count_q < DEPTH_C) ? '0 : wr_ptr_q;
        rd_ptr_d = raddr + PTR_ONE;
        remain_d = count_q;
        state_d  = TRC_READ;
      end
      TRC_READ: begin
        // The RAM read register doubles as the output stage; it only
        // advances on a handshake, so data holds through a stall.
        if (rd_ready_i) begin
          re       = 1'b1;
          raddr    = rd_ptr_q;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          remain_d = remain_q - CNT_ONE;
          if (remain_q == CNT_ONE) begin
            state_d = TRC_IDLE;
          end
        end
      end
      default: begin
        state_d = TRC_IDLE;
      end
    endcase

    if (we) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (count_q == DEPTH_C) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= TRC_IDLE;
      cyc_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remain_q    <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      remain_q    <= remain_d;
      post_cnt_q  <= post_cnt_d;
      triggered_q <= triggered_d;
      overflow_q  <= overflow_d;
    end
  end

  pipeline_trace_buffer_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_trace_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  assign rd_valid_o  = (state_q == TRC_READ);
  assign rd_last_o   = rd_valid_o && (remain_q == CNT_ONE);
  // RAM read register is unreset; mask it so the dump port reads 0 outside READ.
  assign rd_data_o   = ram_rdata & {EW{rd_valid_o}};
  assign busy_o      = (state_q != TRC_IDLE);
  assign triggered_o = triggered_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed bench for pipeline_trace_buffer: scoreboard of expected entries checked against the dump.
module tb_pipeline_trace_buffer;

  localparam int CH  = 4;
  localparam int CHW = 8;
  localparam int DEP = 8;
  localparam int PT  = 3;
  localparam int CYW = 16;
  localparam int EW  = CYW + CH + CH * CHW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          arm0 = 1'b0, arm1 = 1'b0, trig = 1'b0, ready = 1'b1, sel = 1'b0;
  logic [CH-1:0] ch_v = '0, mask = '0;
  logic [CH*CHW-1:0] ch_data = '0;

  logic          rv0, last0, busy0, trg0, ovf0;
  logic          rv1, last1, busy1, trg1, ovf1;
  logic [EW-1:0] rd0, rd1;

  pipeline_trace_buffer #(
    .CHANNELS(CH), .CH_WIDTH(CHW), .DEPTH(DEP), .POST_TRIG(PT), .CYC_WIDTH(CYW), .FILTER(0)
  ) u_dut (
    .clk(clk), .rst(rst), .arm_i(arm0), .ch_v_i(ch_v), .ch_data_i(ch_data),
    .trig_mask_i(mask), .trig_i(trig), .rd_ready_i(ready),
    .rd_valid_o(rv0), .rd_data_o(rd0), .rd_last_o(last0), .busy_o(busy0),
    .triggered_o(trg0), .overflow_o(ovf0)
  );

  pipeline_trace_buffer #(
    .CHANNELS(CH), .CH_WIDTH(CHW), .DEPTH(DEP), .POST_TRIG(PT), .CYC_WIDTH(CYW), .FILTER(1)
  ) u_dut_f (
    .clk(clk), .rst(rst), .arm_i(arm1), .ch_v_i(ch_v), .ch_data_i(ch_data),
    .trig_mask_i(mask), .trig_i(trig), .rd_ready_i(ready),
    .rd_valid_o(rv1), .rd_data_o(rd1), .rd_last_o(last1), .busy_o(busy1),
    .triggered_o(trg1), .overflow_o(ovf1)
  );

  logic          rv, rlast, rbusy, rtrg, rovf;
  logic [EW-1:0] rdat;
  assign rv    = sel ? rv1 : rv0;
  assign rlast = sel ? last1 : last0;
  assign rbusy = sel ? busy1 : busy0;
  assign rtrg  = sel ? trg1 : trg0;
  assign rovf  = sel ? ovf1 : ovf0;
  assign rdat  = sel ? rd1 : rd0;

  logic [CYW-1:0] cyc_m;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc_m <= '0;
    else     cyc_m <= cyc_m + 16'd1;
  end

  int n_checks = 0;
  int n_err    = 0;
  int m_phase  = 0;
  int m_post   = 0;
  bit m_ovf    = 1'b0;
  logic [EW-1:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [CH-1:0] v, input logic [CH*CHW-1:0] d);
    exp_q.push_back({cyc_m, v, d});
    if (exp_q.size() > DEP) begin
      void'(exp_q.pop_front());
      m_ovf = 1'b1;
    end
  endtask

  // Drive one cycle of probes and advance the expected-capture model.
  task automatic drive(input bit a, input bit t, input logic [CH-1:0] v, input logic [CH*CHW-1:0] d);
    bit hit, qual;
    arm0 = a & ~sel;
    arm1 = a & sel;
    trig = t;
    ch_v = v;
    ch_data = d;
    hit  = t | (|(v & mask));
    qual = sel ? (|v) : 1'b1;
    case (m_phase)
      0: if (a) begin m_phase = 1; exp_q.delete(); m_ovf = 1'b0; end
      1: begin
        if (hit || qual) push(v, d);
        if (hit) begin m_post = PT; m_phase = 2; end
      end
      2: if (qual) begin
        push(v, d);
        m_post--;
        if (m_post == 0) m_phase = 3;
      end
      default: ;
    endcase
    step();
    arm0 = 1'b0;
    arm1 = 1'b0;
    trig = 1'b0;
  endtask

  task automatic drain_latency(input string tag);
    chk({tag, "_drain_valid"}, rv, 0);
    chk({tag, "_drain_busy"}, rbusy, 1);
    step();
    chk({tag, "_first_valid"}, rv, 1);
  endtask

  task automatic readout(input string tag, input int stall_idx, input int arm_idx);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    while (!rv && guard < 20) begin step(); guard++; end
    chk({tag, "_valid_wait"}, rv, 1);
    if (rv) begin
      chk({tag, "_triggered"}, rtrg, 1);
      chk({tag, "_overflow"}, rovf, m_ovf);
      while (exp_q.size() > 0) begin
        chk({tag, "_rd_valid"}, rv, 1);
        chk({tag, "_rd_data"}, rdat, exp_q[0]);
        chk({tag, "_rd_last"}, rlast, exp_q.size() == 1);
        $display("%s entry %0d stamp=%0d ch_v=%b data=%h last=%0b", tag, idx,
                 rdat[EW-1 -: CYW], rdat[CH*CHW +: CH], rdat[CH*CHW-1:0], rlast);
        if (idx == stall_idx) begin
          ready = 1'b0;
          repeat (3) begin
            step();
            chk({tag, "_stall_valid"}, rv, 1);
            chk({tag, "_stall_data"}, rdat, exp_q[0]);
          end
          ready = 1'b1;
        end
        if (idx == arm_idx) begin
          arm0 = ~sel;
          arm1 = sel;
        end
        void'(exp_q.pop_front());
        step();
        arm0 = 1'b0;
        arm1 = 1'b0;
        idx++;
      end
    end
    exp_q.delete();
    m_phase = 0;
    chk({tag, "_done_valid"}, rv, 0);
    chk({tag, "_done_busy"}, rbusy, 0);
  endtask

  function automatic logic [CH-1:0] rnd_v();
    return CH'($urandom_range(0, 15));
  endfunction

  function automatic logic [CH*CHW-1:0] rnd_d();
    return $urandom;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [CH-1:0] v;

    // Reset state
    step();
    chk("rst_flags0", {rv0, last0, busy0, trg0, ovf0}, 0);
    chk("rst_data0", rd0, 0);
    chk("rst_flags1", {rv1, last1, busy1, trg1, ovf1}, 0);
    step();
    rst = 1'b0;

    // T1: arm at cyc 10, trigger at cyc 15, stall mid-dump
    sel = 1'b0; mask = '0;
    while (cyc_m != 16'd10) drive(0, 0, rnd_v(), rnd_d());
    drive(1, 0, rnd_v(), rnd_d());
    chk("t1_busy_after_arm", busy0, 1);
    while (cyc_m != 16'd15) drive(0, 0, rnd_v(), rnd_d());
    drive(0, 1, rnd_v(), rnd_d());
    g = 0;
    while (m_phase != 3 && g < 20) begin drive(0, 0, rnd_v(), rnd_d()); g++; end
    drain_latency("t1");
    chk("t1_first_stamp", rdat[EW-1 -: CYW], 16'd11);
    readout("t1", 4, -1);

    // T2: trigger in arm cycle ignored, wrap gives overflow, arm during READ ignored
    drive(1, 1, rnd_v(), rnd_d());
    repeat (29) drive(0, 0, rnd_v(), rnd_d());
    chk("t2_arm_trig_ignored", trg0, 0);
    chk("t2_still_capturing", {busy0, rv0}, 2'b10);
    drive(0, 1, rnd_v(), rnd_d());
    g = 0;
    while (m_phase != 3 && g < 20) begin drive(0, 0, rnd_v(), rnd_d()); g++; end
    drain_latency("t2");
    readout("t2", -1, 2);
    step();
    chk("t2_arm_in_read_ignored", busy0, 0);

    // T3: filtered capture, channel 2 triggers, masked-out channel 0 active on even cycles
    sel = 1'b1; mask = 4'b0100;
    drive(1, 0, 4'b0000, rnd_d());
    repeat (6) begin
      v = cyc_m[0] ? 4'b0000 : (4'b0001 | (rnd_v() & 4'b1010));
      drive(0, 0, v, rnd_d());
    end
    chk("t3_ch0_no_trigger", trg1, 0);
    if (cyc_m[0]) drive(0, 0, 4'b0000, rnd_d());
    drive(0, 0, 4'b0101, rnd_d());
    g = 0;
    while (m_phase != 3 && g < 20) begin
      v = cyc_m[0] ? 4'b0000 : (4'b0001 | (rnd_v() & 4'b1010));
      drive(0, 0, v, rnd_d());
      g++;
    end
    drain_latency("t3");
    readout("t3", -1, -1);

    // T4: reset during POST aborts; re-arm yields a clean dump
    sel = 1'b0; mask = '0;
    drive(1, 0, rnd_v(), rnd_d());
    repeat (4) drive(0, 0, rnd_v(), rnd_d());
    drive(0, 1, rnd_v(), rnd_d());
    drive(0, 0, rnd_v(), rnd_d());
    chk("t4_in_post_busy", busy0, 1);
    rst = 1'b1;
    #1;
    chk("t4_rst_flags", {rv0, last0, busy0, trg0, ovf0}, 0);
    chk("t4_rst_data", rd0, 0);
    step();
    rst = 1'b0;
    m_phase = 0;
    exp_q.delete();
    drive(1, 0, rnd_v(), rnd_d());
    repeat (5) drive(0, 0, rnd_v(), rnd_d());
    drive(0, 1, rnd_v(), rnd_d());
    g = 0;
    while (m_phase != 3 && g < 20) begin drive(0, 0, rnd_v(), rnd_d()); g++; end
    drain_latency("t4");
    readout("t4", 1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
